// File: rtl/addsub_accum_unit.sv
// Registered add/subtract/accumulate unit with valid/ready handshakes,
// raw carry/borrow flag, zero flag and optional unsigned saturation.
module addsub_accum_unit #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  logic             accept;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a_eff = acc_clr ? '0 : acc;
    lhs   = op[1] ? a_eff : in1;
    rhs   = op[1] ? in1   : in2;
    if (op[0]) sum = {1'b0, lhs} - {1'b0, rhs};
    else       sum = {1'b0, lhs} + {1'b0, rhs};
    res = sum[WIDTH-1:0];
    // op[0] selects clamp direction: borrow clamps to 0, carry to all-ones
    if (SATURATE && sum[WIDTH]) res = op[0] ? '0 : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= accept || (out_valid && !out_ready);
      if (accept) begin
        out   <= res;
        carry <= sum[WIDTH];
        zero  <= (res == '0);
      end
      if (accept && op[1]) acc <= res;
      else if (acc_clr)    acc <= '0;
    end
  end

endmodule

// File: tb/tb_addsub_accum_unit.sv
// Directed bench for addsub_accum_unit: a wrapping and a saturating instance
// share one stimulus stream; expected values are hand-computed constants.
module tb_addsub_accum_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] in1, in2;
  logic       acc_clr;
  logic       out_ready;

  logic       w_in_ready, w_out_valid, w_carry, w_zero;
  logic [7:0] w_out, w_acc;
  logic       s_in_ready, s_out_valid, s_carry, s_zero;
  logic [7:0] s_out, s_acc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_accum_unit #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .op(op), .in1(in1), .in2(in2), .acc_clr(acc_clr),
    .out_valid(w_out_valid), .out_ready(out_ready), .out(w_out),
    .carry(w_carry), .zero(w_zero), .acc(w_acc)
  );

  addsub_accum_unit #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .in1(in1), .in2(in2), .acc_clr(acc_clr),
    .out_valid(s_out_valid), .out_ready(out_ready), .out(s_out),
    .carry(s_carry), .zero(s_zero), .acc(s_acc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic clr, input logic rdy);
    in_valid  = v;
    op        = o;
    in1       = a;
    in2       = b;
    acc_clr   = clr;
    out_ready = rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b00, 8'h11, 8'h22, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({w_out_valid, w_out, w_carry, w_zero, w_acc} !== 19'h0) begin
        errors++;
        $display("FAIL reset_wrap: valid=%b out=%h carry=%b zero=%b acc=%h, want all 0",
                 w_out_valid, w_out, w_carry, w_zero, w_acc);
      end
      checks++;
      if ({s_out_valid, s_out, s_carry, s_zero, s_acc} !== 19'h0) begin
        errors++;
        $display("FAIL reset_sat: valid=%b out=%h carry=%b zero=%b acc=%h, want all 0",
                 s_out_valid, s_out, s_carry, s_zero, s_acc);
      end
    end
    rst = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    checks++;
    if (w_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", w_in_ready, s_in_ready);
    end
  endtask

  task automatic test_stream();
    drive(1'b1, 2'b00, 8'h12, 8'h34, 1'b0, 1'b1);
    tick();
    checks++;
    if (w_out_valid !== 1'b1 || w_out !== 8'h46 || w_carry !== 1'b0 || w_zero !== 1'b0) begin
      errors++;
      $display("FAIL stream_add: valid=%b out=%h carry=%b zero=%b, want 1 46 0 0",
               w_out_valid, w_out, w_carry, w_zero);
    end
    drive(1'b1, 2'b01, 8'h10, 8'h20, 1'b0, 1'b1);
    tick();
    checks++;
    if (w_out_valid !== 1'b1 || w_out !== 8'hF0 || w_carry !== 1'b1) begin
      errors++;
      $display("FAIL stream_sub: valid=%b out=%h carry=%b, want 1 f0 1",
               w_out_valid, w_out, w_carry);
    end
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    checks++;
    if (w_out_valid !== 1'b0 || w_out !== 8'hF0) begin
      errors++;
      $display("FAIL stream_drain: valid=%b out=%h, want 0 f0", w_out_valid, w_out);
    end
  endtask

  task automatic test_wrap_saturate();
    drive(1'b1, 2'b00, 8'hFF, 8'h01, 1'b0, 1'b1);
    tick();
    checks++;
    if (w_out !== 8'h00 || w_carry !== 1'b1 || w_zero !== 1'b1) begin
      errors++;
      $display("FAIL wrap_add: out=%h carry=%b zero=%b, want 00 1 1", w_out, w_carry, w_zero);
    end
    checks++;
    if (s_out !== 8'hFF || s_carry !== 1'b1 || s_zero !== 1'b0) begin
      errors++;
      $display("FAIL sat_add_max: out=%h carry=%b zero=%b, want ff 1 0", s_out, s_carry, s_zero);
    end
    drive(1'b1, 2'b01, 8'h00, 8'h01, 1'b0, 1'b1);
    tick();
    checks++;
    if (w_out !== 8'hFF || w_carry !== 1'b1 || w_zero !== 1'b0) begin
      errors++;
      $display("FAIL wrap_sub: out=%h carry=%b zero=%b, want ff 1 0", w_out, w_carry, w_zero);
    end
    drive(1'b1, 2'b00, 8'hF0, 8'h20, 1'b0, 1'b1);
    tick();
    checks++;
    if (s_out !== 8'hFF || s_carry !== 1'b1) begin
      errors++;
      $display("FAIL sat_add: out=%h carry=%b, want ff 1", s_out, s_carry);
    end
    checks++;
    if (w_out !== 8'h10 || w_carry !== 1'b1) begin
      errors++;
      $display("FAIL wrap_add2: out=%h carry=%b, want 10 1", w_out, w_carry);
    end
    drive(1'b1, 2'b01, 8'h05, 8'h09, 1'b0, 1'b1);
    tick();
    checks++;
    if (s_out !== 8'h00 || s_carry !== 1'b1 || s_zero !== 1'b1) begin
      errors++;
      $display("FAIL sat_sub: out=%h carry=%b zero=%b, want 00 1 1", s_out, s_carry, s_zero);
    end
    checks++;
    if (w_out !== 8'hFC || w_carry !== 1'b1 || w_zero !== 1'b0) begin
      errors++;
      $display("FAIL wrap_sub2: out=%h carry=%b zero=%b, want fc 1 0", w_out, w_carry, w_zero);
    end
    drive(1'b1, 2'b01, 8'h09, 8'h05, 1'b0, 1'b1);
    tick();
    checks++;
    if (s_out !== 8'h04 || s_carry !== 1'b0) begin
      errors++;
      $display("FAIL sat_sub_nosat: out=%h carry=%b, want 04 0", s_out, s_carry);
    end
    checks++;
    if (w_acc !== 8'h00 || s_acc !== 8'h00) begin
      errors++;
      $display("FAIL addsub_acc_untouched: acc=%h/%h, want 00/00", w_acc, s_acc);
    end
  endtask

  task automatic test_accumulate();
    logic [1:0] ops [4] = '{2'b10, 2'b10, 2'b11, 2'b10};
    logic [7:0] vals[4] = '{8'h05, 8'h07, 8'h02, 8'h03};
    logic       clrs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] exps[4] = '{8'h05, 8'h0C, 8'h0A, 8'h03};
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], vals[i], 8'hAA, clrs[i], 1'b1);
      tick();
      checks++;
      if (w_acc !== exps[i] || w_out !== exps[i] || s_acc !== exps[i] || w_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL accum_%0d: acc=%h out=%h sacc=%h valid=%b, want %h",
                 i, w_acc, w_out, s_acc, w_out_valid, exps[i]);
      end
    end
    drive(1'b0, 2'b10, 8'h01, 8'h00, 1'b1, 1'b1);
    tick();
    checks++;
    if (w_acc !== 8'h00 || w_out !== 8'h03 || w_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_only: acc=%h out=%h valid=%b, want 00 03 0", w_acc, w_out, w_out_valid);
    end
    drive(1'b1, 2'b10, 8'h09, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b1, 2'b00, 8'h01, 8'h01, 1'b1, 1'b1);
    tick();
    checks++;
    if (w_acc !== 8'h00 || w_out !== 8'h02) begin
      errors++;
      $display("FAIL clr_with_add: acc=%h out=%h, want 00 02", w_acc, w_out);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b00, 8'h01, 8'h02, 1'b0, 1'b1);
    tick();
    drive(1'b1, 2'b00, 8'h10, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (w_in_ready !== 1'b0 || w_out_valid !== 1'b1 || w_out !== 8'h03) begin
        errors++;
        $display("FAIL stall_%0d: in_ready=%b valid=%b out=%h, want 0 1 03",
                 i, w_in_ready, w_out_valid, w_out);
      end
      tick();
    end
    drive(1'b1, 2'b00, 8'h10, 8'h10, 1'b1, 1'b0);
    tick();
    checks++;
    if (w_acc !== 8'h00 || w_out !== 8'h03 || w_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_clr: acc=%h out=%h valid=%b, want 00 03 1", w_acc, w_out, w_out_valid);
    end
    drive(1'b1, 2'b00, 8'h10, 8'h10, 1'b0, 1'b1);
    #1;
    checks++;
    if (w_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: in_ready=%b, want 1", w_in_ready);
    end
    tick();
    checks++;
    if (w_out_valid !== 1'b1 || w_out !== 8'h20) begin
      errors++;
      $display("FAIL release_beat: valid=%b out=%h, want 1 20", w_out_valid, w_out);
    end
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    checks++;
    if (w_out_valid !== 1'b0 || w_out !== 8'h20) begin
      errors++;
      $display("FAIL release_single: valid=%b out=%h, want 0 20", w_out_valid, w_out);
    end
  endtask

  task automatic test_reset_stall();
    drive(1'b1, 2'b10, 8'h0C, 8'h00, 1'b1, 1'b1);
    tick();
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    checks++;
    if (w_acc !== 8'h0C || w_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL prestall: acc=%h valid=%b, want 0c 1", w_acc, w_out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (w_out_valid !== 1'b0 || w_acc !== 8'h00 || w_out !== 8'h00 || s_acc !== 8'h00) begin
      errors++;
      $display("FAIL reset_stall: valid=%b acc=%h out=%h sacc=%h, want 0 00 00 00",
               w_out_valid, w_acc, w_out, s_acc);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    test_reset();
    test_stream();
    test_wrap_saturate();
    test_accumulate();
    test_back_to_back();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
